// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch buffer.
// Holds FSM encoding, default geometry and instruction width.
package ifetch_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 32;
  localparam int ILEN      = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } fstate_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO with flush, occupancy count and head output.
// Head reads as zero while empty so reset leaves outputs clean.
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction prefetch unit: one-outstanding fetch FSM feeding a FIFO.
// Redirects flush the FIFO; in-flight stale reads are drained in DROP.
module ifetch_buffer
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [AW-1:0]   redirect_pc,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_ack,
  input  logic [ILEN-1:0] mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr_data,
  output logic [AW-1:0]   instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AW + ILEN;

  fstate_e       state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] stale_q, stale_d;
  logic [CW-1:0] count;
  logic [CW:0]   occ_next;
  logic [EW-1:0] head;
  logic          push, pop;
  logic          has_room, room_next;

  assign instr_valid = (count != '0);
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign push = (state_q == S_REQ) && mem_ack && !redirect_valid;

  assign has_room  = count < CW'(DEPTH);
  assign occ_next  = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
  assign room_next = occ_next < (CW+1)'(DEPTH);

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({pc_q, mem_rdata}),
    .head_o  (head),
    .count_o (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (push)      pc_d = pc_q + AW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (!redirect_valid && has_room) state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          state_d = mem_ack ? S_IDLE : S_DROP;
          // Keep presenting the in-flight address until it completes
          if (!mem_ack) stale_d = pc_q;
        end else if (mem_ack && !room_next) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (state_q != S_IDLE);
    mem_addr   = (state_q == S_DROP) ? stale_q : pc_q;
    instr_pc   = head[EW-1:ILEN];
    instr_data = head[ILEN-1:0];
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer with a variable-latency memory model.
// Memory returns addr+0x100 for every word address.
module tb_ifetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 0;
  int wcnt   = 0;

  always #5 clk = ~clk;

  ifetch_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  always_ff @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  assign mem_ack   = mem_req && (wcnt >= lat);
  assign mem_rdata = mem_ack ? (mem_addr + 32'h100) : 32'hDEAD_BEEF;

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    lat = 0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mem_req: got %b want 0", mem_req);
    end
    n_chk++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b want 0", instr_valid);
    end
    n_chk++;
    if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_head: got %h/%h want 0/0", instr_pc, instr_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_req: got req=%b addr=%h v=%b want 1/0/0",
               mem_req, mem_addr, instr_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_chk++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(i) ||
          instr_data !== 32'(i + 'h100)) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b pc=%h d=%h want 1/%h/%h",
                 i, instr_valid, instr_pc, instr_data, i, i + 'h100);
      end
    end
  endtask

  task automatic test_backpressure();
    int acks;
    int addr4;
    instr_ready = 1'b0;
    do_reset();
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack) acks++;
    end
    n_chk++;
    if (acks !== 4) begin
      n_fail++;
      $display("FAIL bp_pushes: got %0d want 4", acks);
    end
    n_chk++;
    if (mem_req !== 1'b0 || instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_idle: got req=%b pc=%h want 0/0", mem_req, instr_pc);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    n_chk++;
    if (instr_pc !== 32'h1) begin
      n_fail++;
      $display("FAIL bp_pop_head: got %h want 1", instr_pc);
    end
    acks = 0;
    addr4 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack) begin
        acks++;
        if (mem_addr == 32'h4) addr4++;
      end
    end
    n_chk++;
    if (acks !== 1 || addr4 !== 1) begin
      n_fail++;
      $display("FAIL bp_refill: got %0d reqs (%0d at 4) want 1 (1)",
               acks, addr4);
    end
  endtask

  task automatic test_redirect_drop();
    bit found;
    bit stale_seen;
    bit got;
    instr_ready = 1'b1;
    lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h2 && !mem_ack) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL drop_find_req2: got none want req at 2");
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h2 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_hold: got req=%b addr=%h v=%b want 1/2/0",
               mem_req, mem_addr, instr_valid);
    end
    stale_seen = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        got = 1'b1;
        n_chk++;
        if (instr_pc !== 32'h40 || instr_data !== 32'h140) begin
          n_fail++;
          $display("FAIL drop_next: got %h/%h want 40/140",
                   instr_pc, instr_data);
        end
      end
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL drop_timeout: got no instr want pc 40");
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == 32'h2) stale_seen = 1'b1;
    end
    n_chk++;
    if (stale_seen) begin
      n_fail++;
      $display("FAIL drop_stale: got pc 2 delivered want never");
    end
    lat = 0;
  endtask

  task automatic test_redirect_ack_pop();
    instr_ready = 1'b1;
    lat = 0;
    do_reset();
    repeat (4) @(negedge clk);
    n_chk++;
    if (instr_valid !== 1'b1 || mem_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rap_pre: got v=%b ack=%b want 1/1", instr_valid, mem_ack);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_chk++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rap_flush: got v=%b req=%b want 0/0", instr_valid, mem_req);
    end
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL rap_addr: got req=%b addr=%h want 1/80", mem_req, mem_addr);
    end
    @(negedge clk);
    n_chk++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h80 ||
        instr_data !== 32'h180) begin
      n_fail++;
      $display("FAIL rap_first: got v=%b %h/%h want 1/80/180",
               instr_valid, instr_pc, instr_data);
    end
  endtask

  task automatic test_back_to_back();
    bit bad;
    bit got;
    instr_ready = 1'b1;
    lat = 0;
    do_reset();
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    @(negedge clk);
    redirect_pc = 32'h20;
    n_chk++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_v1: got %b want 0", instr_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    n_chk++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_v2: got v=%b req=%b want 0/0", instr_valid, mem_req);
    end
    bad = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack && mem_addr[31:4] == 28'h1) bad = 1'b1;
      if (instr_valid) begin
        got = 1'b1;
        n_chk++;
        if (instr_pc !== 32'h20 || instr_data !== 32'h120) begin
          n_fail++;
          $display("FAIL b2b_first: got %h/%h want 20/120",
                   instr_pc, instr_data);
        end
      end
    end
    n_chk++;
    if (!got || bad) begin
      n_fail++;
      $display("FAIL b2b_fetch: got seen=%b fetched10=%b want 1/0", got, bad);
    end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    lat = 0;
    do_reset();
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_now: got req=%b v=%b want 0/0", mem_req, instr_valid);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL areset_req: got %b/%h want 1/0", mem_req, mem_addr);
    end
    @(negedge clk);
    n_chk++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 ||
        instr_data !== 32'h100) begin
      n_fail++;
      $display("FAIL areset_first: got v=%b %h/%h want 1/0/100",
               instr_valid, instr_pc, instr_data);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_ack_pop();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
